scl_timing_generator: RTL

Parametrised successor to the single-divisor SCL generator for the I2C controller. Produces a master SCL with independent high/low phase counts, wider divisors and a configurable input synchroniser. Adds multi-master clock synchronisation, a stretch timeout and synchronised edge pulses. Sits between the byte/bit FSM (scl_en, scl_wait) and the open-drain SCL pad (scl_i, scl_o).

---
 rtl/scl_timing_generator.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/scl_timing_generator.sv
// SCL timing generator for the I2C master.
// Drives the open-drain SCL with separate high/low phase counts and
// synchronises the pad input. Another master pulling SCL low ends our high
// phase early. A slave stretching the clock is tracked, and can optionally
// time out. Edge pulses on the synchronised SCL are provided for the bit FSM.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | SCL released, waiting for enable (and no pending timeout)
// HIGH    | SCL released, counting the high phase
// LOW     | SCL driven low, counting the low phase
// HOLD    | SCL driven low past the low phase while scl_wait is set
// RELEASE | SCL released, waiting for the synchronised pad to read high
module scl_timing_generator #(
    parameter int DIV_W       = 16,
    parameter int TMO_W       = 20,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scl_en,
    input  logic             scl_wait,
    input  logic [DIV_W-1:0] scl_hi_cnt,
    input  logic [DIV_W-1:0] scl_lo_cnt,
    input  logic             tmo_en,
    input  logic [TMO_W-1:0] tmo_cnt,
    input  logic             scl_i,
    output logic             scl_o,
    output logic [DIV_W-1:0] scl_hi_cur,
    output logic [DIV_W-1:0] scl_lo_cur,
    output logic             scl_stretched,
    output logic             scl_timeout,
    output logic             scl_rise,
    output logic             scl_fall
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HIGH    = 3'd1,
        ST_LOW     = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    state_t                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   scl_prev_q;
    logic [DIV_W-1:0]       cnt_q;
    logic [TMO_W-1:0]       tmo_q;
    logic [DIV_W-1:0]       hi_cur_q;
    logic [DIV_W-1:0]       lo_cur_q;
    logic                   scl_o_q;
    logic                   stretched_q;
    logic                   timeout_q;

    logic scl_s;
    logic scl_s_nxt;

    // The synchronised pad level, and the value it will take after the next
    // edge; the latter lets scl_stretched be registered yet exact.
    assign scl_s     = sync_q[SYNC_STAGES-1];
    assign scl_s_nxt = sync_q[SYNC_STAGES-2];

    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;

    assign scl_o         = scl_o_q;
    assign scl_hi_cur    = hi_cur_q;
    assign scl_lo_cur    = lo_cur_q;
    assign scl_stretched = stretched_q;
    assign scl_timeout   = timeout_q;

    // Pad synchroniser and edge history; idles high like a released bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q     <= '1;
            scl_prev_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], scl_i};
            scl_prev_q <= scl_s;
        end
    end

    // Phase sequencing, config latching and stretch timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            hi_cur_q    <= '0;
            lo_cur_q    <= '0;
            scl_o_q     <= 1'b1;
            stretched_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else if (!scl_en) begin
            // Disable wins over everything and is the only way to clear a timeout.
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            hi_cur_q    <= scl_hi_cnt;
            lo_cur_q    <= scl_lo_cnt;
            scl_o_q     <= 1'b1;
            stretched_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            stretched_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    scl_o_q <= 1'b1;
                    if (!timeout_q) begin
                        state_q <= ST_HIGH;
                        cnt_q   <= hi_cur_q;
                    end
                end
                ST_HIGH: begin
                    // A foreign pull-down and our own terminal count share one load.
                    if (cnt_q == '0 || scl_fall) begin
                        state_q <= ST_LOW;
                        cnt_q   <= lo_cur_q;
                        scl_o_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_LOW: begin
                    if (cnt_q == '0) begin
                        if (scl_wait) begin
                            state_q <= ST_HOLD;
                        end else begin
                            state_q     <= ST_RELEASE;
                            scl_o_q     <= 1'b1;
                            stretched_q <= ~scl_s_nxt;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!scl_wait) begin
                        state_q     <= ST_RELEASE;
                        scl_o_q     <= 1'b1;
                        stretched_q <= ~scl_s_nxt;
                    end
                end
                ST_RELEASE: begin
                    // Timeout is checked before the rise so it wins a tie.
                    if (tmo_en && tmo_q == tmo_cnt) begin
                        state_q   <= ST_IDLE;
                        timeout_q <= 1'b1;
                        tmo_q     <= '0;
                        scl_o_q   <= 1'b1;
                    end else if (scl_s) begin
                        state_q <= ST_HIGH;
                        cnt_q   <= hi_cur_q;
                        tmo_q   <= '0;
                    end else begin
                        stretched_q <= ~scl_s_nxt;
                        if (tmo_q != '1) begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    scl_o_q <= 1'b1;
                end
            endcase
        end
    end

endmodule
